// File: rtl/serial_to_parallel_rx_pkg.sv
// Shared types for the serial link receiver.
// Holds the receive FSM state encoding.
package serial_to_parallel_rx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rx_state_e;

endpackage

// File: rtl/serial_to_parallel_rx_out_buffer.sv
// Single-entry valid/ready holding register.
// Raises a sticky overrun when a write finds it full.
module rx_out_buffer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_en,
  input  logic [N-1:0] wr_data,
  input  logic         rd_ready,
  input  logic         clr_err,
  output logic [N-1:0] dout,
  output logic         dout_valid,
  output logic         overrun
);

  logic [N-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         ovr_q, ovr_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clr_err) ovr_d = 1'b0;
    if (valid_q && rd_ready) valid_d = 1'b0;
    // a same-cycle read frees the slot for the new word
    if (wr_en) begin
      if (!valid_q || rd_ready) begin
        data_d  = wr_data;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = data_q;
  assign dout_valid = valid_q;
  assign overrun    = ovr_q;

endmodule

// File: rtl/serial_to_parallel_rx.sv
// LSB-first serial word receiver with start framing.
// Completed words go to a single-entry output buffer.
module serial_to_parallel_rx
  import serial_to_parallel_rx_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         si,
  input  logic         si_en,
  input  logic         start,
  input  logic         rd_ready,
  input  logic         clr_err,
  output logic [N-1:0] dout,
  output logic         dout_valid,
  output logic         busy,
  output logic         overrun,
  output logic         frame_err
);

  localparam int CW = $clog2(N);

  rx_state_e    state_q, state_d;
  logic [N-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         ferr_q, ferr_d;
  logic [N-1:0] word;
  logic         word_done;
  logic         recv;

  assign recv = (state_q == ST_RECV);
  assign word = {si, shreg_q[N-1:1]};

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    ferr_d    = ferr_q;
    word_done = 1'b0;
    if (clr_err) ferr_d = 1'b0;
    if (si_en) begin
      unique case (1'b1)
        start: begin
          shreg_d = word;
          cnt_d   = CW'(1);
          state_d = ST_RECV;
          if (recv) ferr_d = 1'b1;
        end
        (!start && recv): begin
          shreg_d = word;
          if (cnt_q == CW'(N - 1)) begin
            cnt_d     = '0;
            state_d   = ST_IDLE;
            word_done = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ferr_q  <= ferr_d;
    end
  end

  rx_out_buffer #(.N(N)) u_out (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (word_done),
    .wr_data    (word),
    .rd_ready   (rd_ready),
    .clr_err    (clr_err),
    .dout       (dout),
    .dout_valid (dout_valid),
    .overrun    (overrun)
  );

  assign busy      = recv;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Self-checking bench: directed scenarios plus random
// stimulus against a bit-indexed behavioural model.
module tb_serial_to_parallel_rx;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         si = 1'b0;
  logic         si_en = 1'b0;
  logic         start = 1'b0;
  logic         rd_ready = 1'b0;
  logic         clr_err = 1'b0;
  logic [N-1:0] dout;
  logic         dout_valid;
  logic         busy;
  logic         overrun;
  logic         frame_err;

  int n_checks = 0;
  int n_pass = 0;

  // model state
  bit         m_in_word;
  int         m_nbits;
  bit [N-1:0] m_bits;
  bit [N-1:0] m_dout;
  bit         m_valid;
  bit         m_ovr;
  bit         m_ferr;

  always #5 clk = ~clk;

  serial_to_parallel_rx #(.N(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .si         (si),
    .si_en      (si_en),
    .start      (start),
    .rd_ready   (rd_ready),
    .clr_err    (clr_err),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h @%0t",
                  name, act, exp, $time);
  endtask

  task automatic m_reset();
    m_in_word = 0; m_nbits = 0; m_bits = '0;
    m_dout = '0; m_valid = 0; m_ovr = 0; m_ferr = 0;
  endtask

  task automatic m_step(input bit b, input bit en, input bit st,
                        input bit rr, input bit clr);
    bit done = 0;
    bit fset = 0;
    bit oset = 0;
    if (en) begin
      if (st) begin
        if (m_in_word) fset = 1;
        m_in_word = 1;
        m_bits = '0;
        m_bits[0] = b;
        m_nbits = 1;
      end else if (m_in_word) begin
        m_bits[m_nbits] = b;
        m_nbits++;
        if (m_nbits == N) begin
          done = 1; m_in_word = 0; m_nbits = 0;
        end
      end
    end
    if (done) begin
      if (!m_valid || rr) begin
        m_dout = m_bits; m_valid = 1;
      end else oset = 1;
    end else if (m_valid && rr) m_valid = 0;
    if (fset) m_ferr = 1; else if (clr) m_ferr = 0;
    if (oset) m_ovr = 1; else if (clr) m_ovr = 0;
  endtask

  task automatic compare();
    chk("dout", 32'(dout), 32'(m_dout));
    chk("dout_valid", 32'(dout_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_in_word));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("frame_err", 32'(frame_err), 32'(m_ferr));
  endtask

  task automatic cyc(input bit b, input bit en, input bit st,
                     input bit rr, input bit clr);
    si = b; si_en = en; start = st; rd_ready = rr; clr_err = clr;
    @(posedge clk);
    m_step(b, en, st, rr, clr);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  // send one N-bit word LSB first; rr applied on the last strobe
  task automatic send(input bit [N-1:0] w, input bit rr_last);
    for (int i = 0; i < N; i++)
      cyc(w[i], 1, i == 0, (i == N - 1) ? rr_last : 1'b0, 0);
  endtask

  initial begin
    m_reset();
    #12;
    compare();
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_valid", 32'(dout_valid), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // basic word 1,0,1,1
    cyc(1, 1, 1, 0, 0);
    chk("busy_b1", 32'(busy), 32'h1);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("busy_b3", 32'(busy), 32'h1);
    cyc(1, 1, 0, 0, 0);
    chk("basic_dout", 32'(dout), 32'hD);
    chk("basic_valid", 32'(dout_valid), 32'h1);
    chk("basic_busy", 32'(busy), 32'h0);
    cyc(0, 0, 0, 1, 0);
    chk("consume", 32'(dout_valid), 32'h0);
    chk("consume_dout", 32'(dout), 32'hD);

    // stray strobe, then gapped bits 0,1,1,0
    cyc(1, 1, 0, 0, 0);
    chk("stray_busy", 32'(busy), 32'h0);
    cyc(0, 1, 1, 0, 0); idle(2);
    cyc(1, 1, 0, 0, 0); idle(2);
    cyc(1, 1, 0, 0, 0); idle(2);
    cyc(0, 1, 0, 0, 0);
    chk("gap_dout", 32'(dout), 32'h6);
    cyc(0, 0, 0, 1, 0);

    // overrun
    send(4'hA, 0);
    idle(1);
    send(4'h5, 0);
    chk("ovr_dout", 32'(dout), 32'hA);
    chk("ovr_flag", 32'(overrun), 32'h1);
    send(4'h3, 1);
    chk("load_rr_dout", 32'(dout), 32'h3);
    chk("load_rr_valid", 32'(dout_valid), 32'h1);
    cyc(0, 0, 0, 1, 1);
    chk("ovr_clr", 32'(overrun), 32'h0);

    // framing restart
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    send(4'hF, 0);
    chk("ferr", 32'(frame_err), 32'h1);
    chk("ferr_dout", 32'(dout), 32'hF);
    cyc(0, 0, 0, 1, 1);
    chk("ferr_clr", 32'(frame_err), 32'h0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 1);
    chk("ferr_set_wins", 32'(frame_err), 32'h1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("ferr_word", 32'(dout), 32'h1);
    cyc(0, 0, 0, 1, 1);

    // async reset mid-word
    send(4'h9, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    compare();
    chk("arst_valid", 32'(dout_valid), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    send(4'h3, 0);
    chk("post_rst", 32'(dout), 32'h3);
    cyc(0, 0, 0, 1, 0);

    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom), $urandom_range(1, 0) == 1,
          $urandom_range(5, 0) == 0, $urandom_range(2, 0) == 0,
          $urandom_range(9, 0) == 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_rx.md
Name: serial_to_parallel_rx

Overview:
Receive end of the team's right-shifting serial link. The matching transmitter shifts out LSB first. This block samples a serial bit stream framed by a start qualifier and assembles N-bit words. Each completed word is presented on a parallel output register with a valid/ready handshake, and sticky overrun and framing error flags are raised on violations.

Parameters:
N, 4, word width in bits; legal range N >= 2.
CW, $clog2(N), bit-counter width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
si  input  1  serial data bit
si_en  input  1  bit strobe; si is sampled only on cycles where si_en=1
start  input  1  frame qualifier; only meaningful with si_en=1; marks si as bit 0 of a new word
rd_ready  input  1  consumer accepts dout this cycle
clr_err  input  1  synchronous clear of overrun and frame_err
dout  output  N  assembled word; bit 0 = first bit received
dout_valid  output  1  dout holds an unconsumed word
busy  output  1  high while in RECV state
overrun  output  1  sticky: completed word dropped because the output was still full
frame_err  output  1  sticky: start seen while a word was partially received

Behaviour:
- Reset (async, reset_n=0): state=IDLE, shift register=0, bit count=0, dout=0, dout_valid=0, overrun=0, frame_err=0, busy=0.
- Shift direction: every accepted bit updates the shift register as shreg <= {si, shreg[N-1:1]}. After N bits, the first bit is in bit 0.
- States:
  - IDLE: si_en=1 with start=1 -> sample bit 0, count=1, go to RECV. si_en=1 with start=0 -> bit ignored. start with si_en=0 -> ignored.
  - RECV, si_en=0: hold all state; gaps between strobes are unlimited.
  - RECV, si_en=1, start=0: shift in bit, count+1.
  - RECV, completion: when the bit just accepted is bit N-1, the word {si, shreg[N-1:1]} completes on that same edge. Go to IDLE, count=0.
  - RECV, si_en=1, start=1: partial word discarded, frame_err<=1, this bit becomes bit 0, count=1, stay in RECV.
- busy = (state==RECV); it is registered and reflects the state after the edge.
- Output register:
  - Completion while dout_valid=0: dout<=word and dout_valid<=1 on the completing edge. Zero extra latency: valid is visible in the cycle after the Nth bit's strobe.
  - Consume: dout_valid=1 and rd_ready=1 -> dout_valid<=0 on the next edge; dout keeps its old value.
  - Completion, dout_valid=1, rd_ready=1 in the same cycle: the new word is loaded, dout_valid stays 1, no overrun.
  - Completion, dout_valid=1, rd_ready=0: the new word is dropped, dout unchanged, overrun<=1.
  - rd_ready while dout_valid=0: no effect.
- Error flags:
  - Sticky until clr_err=1.
  - A set condition and clr_err in the same cycle: set wins.
  - Flags do not affect reception.
- Reset mid-word or with dout_valid=1 returns everything to reset values immediately; the partial or pending word is lost.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package/header: state encoding constants (ST_IDLE=0, ST_RECV=1).
- One sub-module is natural: rx_out_buffer. It is a single-entry valid/ready holding register with an overrun flag, and it is reusable by other receivers in the codebase.
- The shift register and bit counter stay in the top module.

Test Plan:
- Basic word, N=4: strobe bits 1,0,1,1 with start on the first -> dout=4'hD, dout_valid=1 the cycle after the 4th strobe, busy high for 3 cycles. rd_ready=1 -> dout_valid=0 next cycle.
- Gapped strobes: bits 0,1,1,0 with 2 idle cycles between strobes -> dout=4'h6. Count holds across gaps. Stray si_en without start in IDLE beforehand is ignored.
- Back-to-back with overrun: word 4'hA then 4'h5 with rd_ready=0 -> dout stays 4'hA, overrun=1. A third word completing while rd_ready=1 -> dout loaded, dout_valid stays 1.
- Framing restart: start, 2 bits, then start+bit sequence 1,1,1,1 -> frame_err=1, dout=4'hF. clr_err=1 -> frame_err=0 next cycle. clr_err together with a new framing event -> frame_err stays 1.
- Async reset mid-word after 2 bits -> all outputs 0 immediately. A fresh word 4'h3 then receives correctly.
